pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 64, the instruction memory depth in 32-bit words (power of two); AW = log2(IMEM_WORDS).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-005 SHALL have port stall, input, 1 bit, which holds fetch when high.
REQ-006 SHALL have port redirect_valid, input, 1 bit, a branch/jump redirect request (e.g. taken beq).
REQ-007 SHALL have port redirect_pc, input, 64 bits, the redirect target address.
REQ-008 SHALL have port imem_we, input, 1 bit, the instruction memory write enable (loader side).
REQ-009 SHALL have port imem_waddr, input, AW bits, the word index to write.
REQ-010 SHALL have port imem_wdata, input, 32 bits, the instruction word to write.
REQ-011 SHALL have port pc_out, output, 64 bits, the address of the instruction on instr.
REQ-012 SHALL have port instr, output, 32 bits, the fetched instruction word.
REQ-013 SHALL have port instr_valid, output, 1 bit, which is high when instr/pc_out hold a live fetch.
REQ-014 SHALL have port fault, output, 1 bit, a sticky misaligned-redirect flag.

Function
REQ-015 SHALL hold an internal 64-bit fetch pointer fpc (next address to fetch) and a 3-state FSM: IDLE, RUN, FAULT.
REQ-016 SHALL index memory as fpc[AW+1:2]; upper bits ignored, so addresses wrap modulo IMEM_WORDS*4.
REQ-017 SHALL, in IDLE at an edge with rst low, go to RUN with no fetch performed: instr_valid stays 0 and fpc is unchanged.
REQ-018 SHALL, in RUN at an edge with redirect_valid=0 and stall=0, set pc_out<=fpc, instr<=mem[fpc], instr_valid<=1, fpc<=fpc+4 (modulo 2^64), giving one-cycle fetch latency.
REQ-019 SHALL, in RUN at an edge with stall=1 and redirect_valid=0, hold fpc, pc_out, instr and instr_valid unchanged.
REQ-020 SHALL, in RUN at an edge with redirect_valid=1 and redirect_pc[1:0]==0, set fpc<=redirect_pc, instr_valid<=0, and hold pc_out/instr, squashing the sequential fetch and inserting one bubble.
REQ-021 SHALL give redirect priority over stall when both are high.
REQ-022 SHALL, in RUN at an edge with redirect_valid=1 and redirect_pc[1:0]!=0, go to FAULT with fault<=1, instr_valid<=0, and fpc unchanged.
REQ-023 SHALL, in FAULT, hold all outputs and fpc, ignoring stall and redirect, until rst.
REQ-024 SHALL, when imem_we=1 at an edge, write mem[imem_waddr]<=imem_wdata in every state and while rst is high.
REQ-025 SHALL, when a write and a fetch target the same word at the same edge, deliver the old word on instr (read-before-write).
REQ-026 SHALL NOT fetch or redirect in IDLE; redirect_valid in IDLE is ignored.

Reset
REQ-027 SHALL, at an edge with rst high, set state to IDLE, fpc to RESET_PC, pc_out to 0, instr to 0, instr_valid to 0 and fault to 0, overriding any stall or redirect.
REQ-028 SHALL NOT clear memory contents on reset.
REQ-029 SHALL, on rst asserted mid-operation, discard any in-flight fetch; the first valid instruction after release is at RESET_PC.

Verification
REQ-030 SHALL be verified for reset/sequential fetch: RESET_PC=8, mem[2]=0x00628463, mem[3]=0xFE533A23, release rst -> instr_valid=0 on the first edge, then edge 2 gives pc_out=8/instr=0x00628463, and edge 3 gives pc_out=0xC/instr=0xFE533A23.
REQ-031 SHALL be verified for redirect: while at pc_out=8, pulse redirect_valid with redirect_pc=0x30 -> the next edge gives instr_valid=0 and the following edge gives pc_out=0x30, instr=mem[12], valid=1.
REQ-032 SHALL be verified for stall and priority: stall=1 for 3 cycles -> outputs frozen; stall=1 with redirect_valid=1 and target 0x20 -> redirect taken.
REQ-033 SHALL be verified for misalignment: redirect_pc=0x22 -> fault=1, instr_valid=0 held for 10 cycles; rst -> fault=0 and fetch resumes at RESET_PC.
REQ-034 SHALL be verified for wrap and write collision: fetch at word IMEM_WORDS-1 -> next pc_out=+4 and instr=mem[0]; a write to the word being fetched -> old value, then new value on refetch.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: sequential PC, redirect/stall control, a sticky
// misalignment fault and a single-port-write instruction memory with registered read.
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter int          AW         = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [63:0]   redirect_pc,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    output logic [63:0]   pc_out,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic          fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [31:0]   r_mem [IMEM_WORDS];
    logic [1:0]    r_state;
    logic [63:0]   r_fpc;
    logic [63:0]   r_pc_out;
    logic [31:0]   r_instr;
    logic          r_valid;
    logic          r_fault;
    logic [AW-1:0] w_fetch_idx;
    logic          w_misaligned;

    // Upper fetch-pointer bits are ignored so fetches wrap around the memory.
    assign w_fetch_idx  = r_fpc[AW+1:2];
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    // Loader port stays live in every state, including reset; contents persist.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_mem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_fpc    <= RESET_PC;
            r_pc_out <= 64'd0;
            r_instr  <= 32'd0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (redirect_valid) begin
                        r_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_fpc <= redirect_pc;
                        end
                    end else if (!stall) begin
                        // Read sees the pre-write word when the loader hits the same index.
                        r_pc_out <= r_fpc;
                        r_instr  <= r_mem[w_fetch_idx];
                        r_valid  <= 1'b1;
                        r_fpc    <= r_fpc + 64'd4;
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc_out      = r_pc_out;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign fault       = r_fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch, redirect, stall priority, fault, wrap and write collision.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [63:0] pc_out;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_unit #(
        .RESET_PC   (64'h8),
        .IMEM_WORDS (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .pc_out         (pc_out),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [63:0] epc, input logic [31:0] ein);
        chk({tag, ".pc"}, pc_out, epc);
        chk({tag, ".instr"}, {32'd0, instr}, {32'd0, ein});
        chk({tag, ".valid"}, {63'd0, instr_valid}, 64'd1);
        $display("step %s: pc_out=%h instr=%h valid=%0b fault=%0b", tag, pc_out, instr, instr_valid, fault);
    endtask

    task automatic chk_bubble(input string tag, input logic [63:0] epc, input logic [31:0] ein);
        chk({tag, ".pc"}, pc_out, epc);
        chk({tag, ".instr"}, {32'd0, instr}, {32'd0, ein});
        chk({tag, ".valid"}, {63'd0, instr_valid}, 64'd0);
        $display("step %s: pc_out=%h instr=%h valid=%0b fault=%0b", tag, pc_out, instr, instr_valid, fault);
    endtask

    task automatic redirect_to(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        imem_we = 1'b0; imem_waddr = 6'd0; imem_wdata = 32'd0;

        // Load memory while reset is held: word i = C0DE_00ii, then words 2/3 overridden.
        for (int i = 0; i < 64; i++) begin
            imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = 32'hC0DE_0000 | 32'(i);
            tick();
        end
        imem_waddr = 6'd2; imem_wdata = 32'h0062_8463; tick();
        imem_waddr = 6'd3; imem_wdata = 32'hFE53_3A23; tick();
        imem_we = 1'b0;

        chk("rst.pc", pc_out, 64'd0);
        chk("rst.instr", {32'd0, instr}, 64'd0);
        chk("rst.valid", {63'd0, instr_valid}, 64'd0);
        chk("rst.fault", {63'd0, fault}, 64'd0);

        // Sequential fetch from RESET_PC.
        rst = 1'b0;
        tick(); chk_bubble("seq.e1", 64'd0, 32'd0);
        tick(); chk_fetch("seq.e2", 64'h8, 32'h0062_8463);
        tick(); chk_fetch("seq.e3", 64'hC, 32'hFE53_3A23);

        // Mid-run reset discards state; redirect from pc_out=8.
        rst = 1'b1; tick();
        chk_bubble("rst2", 64'd0, 32'd0);
        rst = 1'b0;
        tick(); tick(); chk_fetch("rd.pre", 64'h8, 32'h0062_8463);
        redirect_to(64'h30);
        chk_bubble("rd.bubble", 64'h8, 32'h0062_8463);
        tick(); chk_fetch("rd.tgt", 64'h30, 32'hC0DE_000C);

        // Stall freezes outputs.
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(); chk_fetch("stall", 64'h30, 32'hC0DE_000C);
        end
        // Redirect wins over stall.
        redirect_to(64'h20);
        chk_bubble("prio.bubble", 64'h30, 32'hC0DE_000C);
        stall = 1'b0;
        tick(); chk_fetch("prio.tgt", 64'h20, 32'hC0DE_0008);
        tick(); chk_fetch("prio.next", 64'h24, 32'hC0DE_0009);

        // Misaligned redirect: sticky fault, everything frozen.
        redirect_to(64'h22);
        chk("mis.fault", {63'd0, fault}, 64'd1);
        chk_bubble("mis.e0", 64'h24, 32'hC0DE_0009);
        for (int c = 0; c < 10; c++) begin
            stall = c[0]; redirect_valid = c[1]; redirect_pc = 64'h40;
            tick();
            chk("mis.hold.fault", {63'd0, fault}, 64'd1);
            chk_bubble("mis.hold", 64'h24, 32'hC0DE_0009);
        end
        stall = 1'b0; redirect_valid = 1'b0;
        rst = 1'b1; tick();
        chk("mis.rst.fault", {63'd0, fault}, 64'd0);
        chk_bubble("mis.rst", 64'd0, 32'd0);
        // Redirect in IDLE is ignored.
        rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h40;
        tick(); chk_bubble("idle.redir", 64'd0, 32'd0);
        redirect_valid = 1'b0;
        tick(); chk_fetch("resume", 64'h8, 32'h0062_8463);

        // Wrap at the last memory word.
        redirect_to(64'hFC);
        chk_bubble("wrap.bubble", 64'h8, 32'h0062_8463);
        tick(); chk_fetch("wrap.last", 64'hFC, 32'hC0DE_003F);
        tick(); chk_fetch("wrap.first", 64'h100, 32'hC0DE_0000);

        // Write collides with fetch of word 1: old word now, new word on refetch.
        imem_we = 1'b1; imem_waddr = 6'd1; imem_wdata = 32'hDEAD_BEEF;
        tick(); imem_we = 1'b0;
        chk_fetch("coll.old", 64'h104, 32'hC0DE_0001);
        redirect_to(64'h104);
        chk_bubble("coll.bubble", 64'h104, 32'hC0DE_0001);
        tick(); chk_fetch("coll.new", 64'h104, 32'hDEAD_BEEF);

        // 64-bit pointer wraps to zero.
        redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
        tick(); chk_fetch("wrap64.top", 64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DE_003F);
        tick(); chk_fetch("wrap64.zero", 64'h0, 32'hC0DE_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
